// File: rtl/armleocpu_simple_clint_if.sv
// Simple-bus link between armleocpu_axi2simple_converter (master) and the CLINT (slave).
interface armleocpu_simple_clint_if #(
  parameter int ADDR_WIDTH = 34
) ();
  logic [ADDR_WIDTH-1:0] address;
  logic                  write;
  logic [31:0]           write_data;
  logic [3:0]            write_byteenable;
  logic                  read;
  logic [31:0]           read_data;
  logic                  address_error;
  logic                  write_error;

  modport master (
    output address, write, write_data, write_byteenable, read,
    input  read_data, address_error, write_error
  );

  modport slave (
    input  address, write, write_data, write_byteenable, read,
    output read_data, address_error, write_error
  );
endinterface

// File: rtl/armleocpu_simple_clint.sv
// Single-hart CLINT: MSIP, PRESCALER, STATUS, MTIMECMP and MTIME on the simple bus.
// Optional ARMLEOCPU_CLINT_HI_LATCH_EN: an MTIME lo read latches mtime[63:32] for a coherent hi read.
module armleocpu_simple_clint #(
  parameter int          ADDR_WIDTH      = 34,
  parameter logic [31:0] PRESCALER_RESET = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  armleocpu_simple_clint_if.slave bus,
  output logic                    timer_irq,
  output logic                    soft_irq,
  input  logic                    mtime_stop
);

  localparam logic [15:0] A_MSIP     = 16'h0000;
  localparam logic [15:0] A_PRESC    = 16'h0010;
  localparam logic [15:0] A_STATUS   = 16'h0014;
  localparam logic [15:0] A_CMP_LO   = 16'h4000;
  localparam logic [15:0] A_CMP_HI   = 16'h4004;
  localparam logic [15:0] A_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] A_MTIME_HI = 16'hBFFC;

  logic        msip_q, msip_d;
  logic [31:0] prescaler_q, prescaler_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        timer_irq_q, soft_irq_q;

  logic [15:0] addr;
  logic        sel_msip, sel_presc, sel_status;
  logic        sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
  logic        addr_err, wr_err, wr_en, tick;
  logic [31:0] mtime_hi_rd;
  logic [31:0] rdata;
  logic        unused_bus;

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  assign addr = bus.address[15:0];

  always_comb begin
    sel_msip   = (addr == A_MSIP);
    sel_presc  = (addr == A_PRESC);
    sel_status = (addr == A_STATUS);
    sel_cmp_lo = (addr == A_CMP_LO);
    sel_cmp_hi = (addr == A_CMP_HI);
    sel_mt_lo  = (addr == A_MTIME_LO);
    sel_mt_hi  = (addr == A_MTIME_HI);
  end

  assign addr_err = (addr[1:0] != 2'b00) ||
                    !(sel_msip | sel_presc | sel_status | sel_cmp_lo |
                      sel_cmp_hi | sel_mt_lo | sel_mt_hi);
  assign wr_err   = sel_status && !addr_err;
  assign wr_en    = bus.write && !addr_err && !wr_err;
  assign tick     = !mtime_stop && (cnt_q == prescaler_q);

  // A bus write to either MTIME half replaces the whole incremented value,
  // so the increment is simply overridden rather than masked per half.
  always_comb begin
    msip_d      = msip_q;
    prescaler_d = prescaler_q;
    mtimecmp_d  = mtimecmp_q;
    cnt_d       = cnt_q;
    mtime_d     = mtime_q;
    if (!mtime_stop) cnt_d = tick ? '0 : cnt_q + 32'd1;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr_en) begin
      if (sel_msip && bus.write_byteenable[0]) msip_d = bus.write_data[0];
      if (sel_presc) begin
        prescaler_d = be_merge(prescaler_q, bus.write_data, bus.write_byteenable);
        cnt_d       = '0;
      end
      if (sel_cmp_lo)
        mtimecmp_d[31:0] = be_merge(mtimecmp_q[31:0], bus.write_data, bus.write_byteenable);
      if (sel_cmp_hi)
        mtimecmp_d[63:32] = be_merge(mtimecmp_q[63:32], bus.write_data, bus.write_byteenable);
      if (sel_mt_lo)
        mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], bus.write_data, bus.write_byteenable)};
      if (sel_mt_hi)
        mtime_d = {be_merge(mtime_q[63:32], bus.write_data, bus.write_byteenable), mtime_q[31:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip_q      <= 1'b0;
      prescaler_q <= PRESCALER_RESET;
      cnt_q       <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
      soft_irq_q  <= 1'b0;
    end else begin
      msip_q      <= msip_d;
      prescaler_q <= prescaler_d;
      cnt_q       <= cnt_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= (mtime_d >= mtimecmp_d);
      soft_irq_q  <= msip_d;
    end
  end

`ifdef ARMLEOCPU_CLINT_HI_LATCH_EN
  logic [31:0] hi_shadow_q, hi_shadow_d;

  always_comb begin
    hi_shadow_d = hi_shadow_q;
    if (bus.read && sel_mt_lo && !addr_err) hi_shadow_d = mtime_q[63:32];
    if (wr_en && sel_mt_hi) hi_shadow_d = mtime_d[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_shadow_q <= '0;
    else        hi_shadow_q <= hi_shadow_d;
  end

  assign mtime_hi_rd = hi_shadow_q;
  assign unused_bus  = ^bus.address[ADDR_WIDTH-1:16];
`else
  assign mtime_hi_rd = mtime_q[63:32];
  assign unused_bus  = ^{bus.address[ADDR_WIDTH-1:16], bus.read};
`endif

  always_comb begin
    rdata = '0;
    if (!addr_err) begin
      if (sel_msip)   rdata = {31'b0, msip_q};
      if (sel_presc)  rdata = prescaler_q;
      if (sel_status) rdata = {30'b0, soft_irq_q, timer_irq_q};
      if (sel_cmp_lo) rdata = mtimecmp_q[31:0];
      if (sel_cmp_hi) rdata = mtimecmp_q[63:32];
      if (sel_mt_lo)  rdata = mtime_q[31:0];
      if (sel_mt_hi)  rdata = mtime_hi_rd;
    end
  end

  assign bus.read_data     = rdata;
  assign bus.address_error = addr_err;
  assign bus.write_error   = wr_err;
  assign timer_irq         = timer_irq_q;
  assign soft_irq          = soft_irq_q;

endmodule
